// File: rtl/im2col_ctrl_if.sv
// Handshake and index bundle between the im2col sequencer and its surroundings.
// The slave modport is the sequencer's view; master is the driving environment.
interface im2col_ctrl_if #(
  parameter int unsigned IDX_W = 4
);
  logic             start;
  logic             abort;
  logic             fm_valid;
  logic             fm_ack;
  logic             load;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] col_idx;
  logic [IDX_W-1:0] beat_idx;
  logic             last;
  logic             busy;
  logic             done;

  modport slave (
    input  start, abort, fm_valid, out_ready,
    output fm_ack, load, out_valid, col_idx, beat_idx, last, busy, done
  );

  modport master (
    output start, abort, fm_valid, out_ready,
    input  fm_ack, load, out_valid, col_idx, beat_idx, last, busy, done
  );
endinterface

// File: rtl/im2col_ctrl.sv
// Sequencer for one im2col job: waits for a feature map, loads it, then walks
// every (column, beat) pair toward a ready/valid consumer.
module im2col_ctrl #(
  parameter int unsigned N_COL  = 12,
  parameter int unsigned N_BEAT = 9,
  parameter int unsigned IDX_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  im2col_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [IDX_W-1:0] COL_LAST  = IDX_W'(N_COL - 1);
  localparam logic [IDX_W-1:0] BEAT_LAST = IDX_W'(N_BEAT - 1);

  logic [2:0]       state, state_nxt;
  logic [IDX_W-1:0] col, col_nxt;
  logic [IDX_W-1:0] beat, beat_nxt;
  logic             xfer;
  logic             at_end;

  assign xfer   = (state == S_STREAM) && bus.out_ready;
  assign at_end = (col == COL_LAST) && (beat == BEAT_LAST);

  // State and index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      col   <= '0;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      beat  <= beat_nxt;
    end
  end

  // Next-state and index update
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    beat_nxt  = beat;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_WAIT;
      S_WAIT: if (bus.fm_valid) state_nxt = S_LOAD;
      S_LOAD: begin
        col_nxt   = '0;
        beat_nxt  = '0;
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (xfer) begin
          if (at_end) begin
            state_nxt = S_DONE;
            col_nxt   = '0;
            beat_nxt  = '0;
          end else if (beat == BEAT_LAST) begin
            beat_nxt = '0;
            col_nxt  = col + IDX_W'(1);
          end else begin
            beat_nxt = beat + IDX_W'(1);
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides everything, including a transfer in the same cycle
    if (bus.abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      col_nxt   = '0;
      beat_nxt  = '0;
    end
  end

  // Outputs decode directly from the state register, so reset clears them at once
  assign bus.load      = (state == S_LOAD);
  assign bus.fm_ack    = (state == S_LOAD);
  assign bus.out_valid = (state == S_STREAM);
  assign bus.last      = (state == S_STREAM) && at_end;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.col_idx   = col;
  assign bus.beat_idx  = beat;

endmodule

// File: tb/tb_im2col_ctrl.sv
// Directed bench for im2col_ctrl: nominal run, backpressure, late map, aborts
// and asynchronous reset, checked against hand-derived cycle expectations.
module tb_im2col_ctrl;

  localparam int unsigned N_COL  = 12;
  localparam int unsigned N_BEAT = 9;
  localparam int unsigned IDX_W  = 4;
  localparam int TOTAL = N_COL * N_BEAT;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_load = 0;
  int   n_done = 0;

  im2col_ctrl_if #(.IDX_W(IDX_W)) bus ();

  im2col_ctrl #(.N_COL(N_COL), .N_BEAT(N_BEAT), .IDX_W(IDX_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.load === 1'b1) n_load++;
    if (bus.done === 1'b1) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.busy),      0);
    chk({tag, "_load"},  32'(bus.load),      0);
    chk({tag, "_ack"},   32'(bus.fm_ack),    0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_last"},  32'(bus.last),      0);
    chk({tag, "_done"},  32'(bus.done),      0);
    chk({tag, "_col"},   32'(bus.col_idx),   0);
    chk({tag, "_beat"},  32'(bus.beat_idx),  0);
  endtask

  // Advance until the DUT presents beat (c,b); bounded.
  task automatic wait_beat(input int c, input int b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.out_valid === 1'b1 && int'(bus.col_idx) == c && int'(bus.beat_idx) == b) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // With out_ready held 1, count valid beats until done; bounded.
  task automatic run_to_done(output int beats, output bit ok);
    beats = 0;
    ok    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (bus.out_valid === 1'b1) beats++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  l0, d0, k, nb;
    bit  ok, seen_done;

    bus.start = 1'b0; bus.abort = 1'b0; bus.fm_valid = 1'b0; bus.out_ready = 1'b0;

    // Reset
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(bus.busy), 0);

    // Nominal job: start sampled at edge 0
    l0 = n_load; d0 = n_done;
    bus.start = 1'b1; bus.fm_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    chk("nom_c1_busy", 32'(bus.busy), 1);
    chk("nom_c1_load", 32'(bus.load), 0);
    step();
    chk("nom_c2_load",  32'(bus.load),      1);
    chk("nom_c2_ack",   32'(bus.fm_ack),    1);
    chk("nom_c2_valid", 32'(bus.out_valid), 0);
    for (int i = 0; i < TOTAL; i++) begin
      step();
      chk("nom_valid", 32'(bus.out_valid), 1);
      chk("nom_col",   32'(bus.col_idx),   32'(i / N_BEAT));
      chk("nom_beat",  32'(bus.beat_idx),  32'(i % N_BEAT));
      chk("nom_last",  32'(bus.last),      32'(i == TOTAL - 1));
      chk("nom_load0", 32'(bus.load),      0);
    end
    step();
    chk("nom_c111_done",  32'(bus.done),      1);
    chk("nom_c111_valid", 32'(bus.out_valid), 0);
    chk("nom_c111_busy",  32'(bus.busy),      1);
    step();
    chk("nom_c112_busy", 32'(bus.busy), 0);
    chk("nom_c112_done", 32'(bus.done), 0);
    chk("nom_loads", 32'(n_load - l0), 1);
    chk("nom_dones", 32'(n_done - d0), 1);

    // Backpressure 1,0,1,0 with stray starts mid-stream and in DONE
    l0 = n_load; d0 = n_done;
    bus.start = 1'b1; bus.out_ready = 1'b0;
    step();
    bus.start = 1'b0;
    k = 0; seen_done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (bus.done === 1'b1) begin
        seen_done = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        break;
      end
      if (bus.out_valid === 1'b1) begin
        chk("bp_col",  32'(bus.col_idx),  32'(k / N_BEAT));
        chk("bp_beat", 32'(bus.beat_idx), 32'(k % N_BEAT));
        chk("bp_last", 32'(bus.last),     32'(k == TOTAL - 1));
        bus.start = (k == 50);
        bus.out_ready = ~bus.out_ready;
        if (bus.out_ready) k++;
      end
    end
    chk("bp_done_seen", 32'(seen_done), 1);
    chk("bp_transfers", 32'(k), 32'(TOTAL));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_idle_after", 32'(bus.busy), 0);
      step();
    end
    chk("bp_loads", 32'(n_load - l0), 1);
    chk("bp_dones", 32'(n_done - d0), 1);

    // Late feature map
    bus.fm_valid = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("late_busy", 32'(bus.busy), 1);
      chk("late_load", 32'(bus.load), 0);
      step();
    end
    bus.fm_valid = 1'b1;
    step();
    chk("late_load_pulse", 32'(bus.load), 1);
    run_to_done(nb, ok);
    chk("late_done", 32'(ok), 1);
    chk("late_beats", 32'(nb), 32'(TOTAL));
    step();

    // Abort during LOAD: pulses still issued, job dropped
    d0 = n_done;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("abl_load", 32'(bus.load),   1);
    chk("abl_ack",  32'(bus.fm_ack), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abl_busy",  32'(bus.busy),      0);
    chk("abl_valid", 32'(bus.out_valid), 0);
    step(); step();
    chk("abl_still_idle", 32'(bus.busy), 0);
    chk("abl_no_done", 32'(n_done - d0), 0);

    // Abort mid-stream at (5,3), with out_ready=1 so a transfer competes
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_beat(5, 3, ok);
    chk("abm_reach", 32'(ok), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abm_valid", 32'(bus.out_valid), 0);
    chk("abm_busy",  32'(bus.busy),      0);
    chk("abm_col",   32'(bus.col_idx),   0);
    chk("abm_beat",  32'(bus.beat_idx),  0);
    step(); step(); step();
    chk("abm_no_done", 32'(n_done - d0), 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_to_done(nb, ok);
    chk("abm_rerun_done",  32'(ok), 1);
    chk("abm_rerun_beats", 32'(nb), 32'(TOTAL));
    step();
    chk("abm_rerun_dones", 32'(n_done - d0), 1);

    // Asynchronous reset between edges at (7,2)
    d0 = n_done;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_beat(7, 2, ok);
    chk("ars_reach", 32'(ok), 1);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("ars");
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ars_idle_busy", 32'(bus.busy), 0);
      chk("ars_idle_load", 32'(bus.load), 0);
    end
    chk("ars_no_done", 32'(n_done - d0), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
